// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC bus sequencer: FSM states, write
// indices and ICW1 bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WS_SETUP  = 3'd1,
    WS_STROBE = 3'd2,
    WS_HOLD   = 3'd3,
    IA1       = 3'd4,
    IA_GAP    = 3'd5,
    IA2       = 3'd6,
    IA_DONE   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    W_ICW1 = 3'd0,
    W_ICW2 = 3'd1,
    W_ICW3 = 3'd2,
    W_ICW4 = 3'd3,
    W_OCW1 = 3'd4,
    W_EOI  = 3'd5
  } widx_t;

  // ICW1 bit positions
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;

  // Next entry of the init list after 'cur', skipping ICW3 in single mode
  // and ICW4 when IC4 is clear. OCW1 is always the last entry.
  function automatic widx_t next_init_write(input widx_t cur, input logic [7:0] icw1);
    widx_t nxt;
    case (cur)
      W_ICW1: nxt = W_ICW2;
      W_ICW2: begin
        if (!icw1[ICW1_SNGL]) begin
          nxt = W_ICW3;
        end else if (icw1[ICW1_IC4]) begin
          nxt = W_ICW4;
        end else begin
          nxt = W_OCW1;
        end
      end
      W_ICW3: begin
        if (icw1[ICW1_IC4]) begin
          nxt = W_ICW4;
        end else begin
          nxt = W_OCW1;
        end
      end
      default: nxt = W_OCW1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Small down-counter that times WR_n / INTA_n pulse widths and the INTA gap.
// Loaded with (cycles - 1); 'zero' flags the last cycle of the interval.
module pic_strobe_timer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/pic_bus_master.sv
// CPU-side bus sequencer for the 8259A-compatible PIC: runs the ICW/OCW1
// init write list, EOI (OCW2) writes and the two-pulse INTA handshake.
// All outputs are registered from the next-state decode.
module pic_bus_master
  import pic_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic [7:0] cfg_ocw1,
  input  logic       eoi_req,
  input  logic [7:0] eoi_cmd,
  input  logic       int_in,
  input  logic [7:0] d_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       inta_n,
  output logic       init_done,
  output logic       busy,
  output logic       vec_valid,
  output logic [7:0] vec
);

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

  state_t     state_r, state_s;
  widx_t      widx_r, widx_s, nxt_init_s;
  logic [7:0] icw2_r, icw3_r, icw4_r, ocw1_r, icw1_r;
  logic       eoi_pend_r;
  logic [7:0] eoi_cmd_r;
  logic       eoi_avail_s;
  logic [7:0] eoi_byte_s;
  logic [7:0] init_byte_s;
  logic       tmr_load_s;
  logic [3:0] tmr_val_s;
  logic       tmr_zero_s;
  logic       a0_s;
  logic [7:0] d_out_s;
  logic       take_start_s, take_eoi_s, set_done_s, capture_s;
  logic       wphase_s;

  pic_strobe_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // A fresh eoi_req competes in the same cycle; otherwise the pending copy.
  assign eoi_avail_s = eoi_pend_r | eoi_req;
  assign eoi_byte_s  = eoi_pend_r ? eoi_cmd_r : eoi_cmd;
  assign nxt_init_s  = next_init_write(widx_r, icw1_r);
  assign wphase_s    = (state_s == WS_SETUP) || (state_s == WS_STROBE) || (state_s == WS_HOLD);

  // Select the latched config byte for the next init-list entry.
  always_comb begin
    init_byte_s = icw1_r;
    case (nxt_init_s)
      W_ICW2:  init_byte_s = icw2_r;
      W_ICW3:  init_byte_s = icw3_r;
      W_ICW4:  init_byte_s = icw4_r;
      W_OCW1:  init_byte_s = ocw1_r;
      default: init_byte_s = icw1_r;
    endcase
  end

  // Next-state, timer control and next bus address/data decode.
  always_comb begin
    state_s      = state_r;
    widx_s       = widx_r;
    tmr_load_s   = 1'b0;
    tmr_val_s    = PULSE_LD;
    a0_s         = a0;
    d_out_s      = d_out;
    take_start_s = 1'b0;
    take_eoi_s   = 1'b0;
    set_done_s   = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Fixed priority: start, then EOI, then interrupt acknowledge.
        if (start) begin
          take_start_s = 1'b1;
          widx_s       = W_ICW1;
          a0_s         = 1'b0;
          d_out_s      = cfg_icw1;
          state_s      = WS_SETUP;
        end else if (eoi_avail_s) begin
          take_eoi_s = 1'b1;
          widx_s     = W_EOI;
          a0_s       = 1'b0;
          d_out_s    = eoi_byte_s;
          state_s    = WS_SETUP;
        end else if (init_done && int_in) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = PULSE_LD;
          state_s    = IA1;
        end else begin
          state_s = IDLE;
        end
      end
      WS_SETUP: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = PULSE_LD;
        state_s    = WS_STROBE;
      end
      WS_STROBE: begin
        if (tmr_zero_s) begin
          state_s = WS_HOLD;
        end else begin
          state_s = WS_STROBE;
        end
      end
      WS_HOLD: begin
        if (widx_r == W_OCW1) begin
          set_done_s = 1'b1;
          state_s    = IDLE;
        end else if (widx_r == W_EOI) begin
          state_s = IDLE;
        end else begin
          widx_s  = nxt_init_s;
          a0_s    = 1'b1;
          d_out_s = init_byte_s;
          state_s = WS_SETUP;
        end
      end
      IA1: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
          state_s    = IA_GAP;
        end else begin
          state_s = IA1;
        end
      end
      IA_GAP: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = PULSE_LD;
          state_s    = IA2;
        end else begin
          state_s = IA_GAP;
        end
      end
      IA2: begin
        if (tmr_zero_s) begin
          capture_s = 1'b1;
          state_s   = IA_DONE;
        end else begin
          state_s = IA2;
        end
      end
      IA_DONE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, registered bus outputs, config latch, EOI pending flag and vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      widx_r     <= W_ICW1;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      rd_n       <= 1'b1;
      inta_n     <= 1'b1;
      a0         <= 1'b0;
      d_out      <= 8'h00;
      d_oe       <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      vec_valid  <= 1'b0;
      vec        <= 8'h00;
      icw1_r     <= 8'h00;
      icw2_r     <= 8'h00;
      icw3_r     <= 8'h00;
      icw4_r     <= 8'h00;
      ocw1_r     <= 8'h00;
      eoi_pend_r <= 1'b0;
      eoi_cmd_r  <= 8'h00;
    end else begin
      state_r   <= state_s;
      widx_r    <= widx_s;
      cs_n      <= ~wphase_s;
      wr_n      <= ~(state_s == WS_STROBE);
      rd_n      <= 1'b1;
      inta_n    <= ~((state_s == IA1) || (state_s == IA2));
      a0        <= a0_s;
      d_out     <= d_out_s;
      d_oe      <= wphase_s;
      busy      <= (state_s != IDLE);
      vec_valid <= (state_s == IA_DONE);
      if (capture_s) begin
        vec <= d_in;
      end
      if (take_start_s) begin
        icw1_r    <= cfg_icw1;
        icw2_r    <= cfg_icw2;
        icw3_r    <= cfg_icw3;
        icw4_r    <= cfg_icw4;
        ocw1_r    <= cfg_ocw1;
        init_done <= 1'b0;
      end else if (set_done_s) begin
        init_done <= 1'b1;
      end
      if (take_eoi_s) begin
        eoi_pend_r <= 1'b0;
      end else if (eoi_req && !eoi_pend_r) begin
        eoi_pend_r <= 1'b1;
        eoi_cmd_r  <= eoi_cmd;
      end
    end
  end

endmodule

// File: doc/pic_bus_master.md
Name: pic_bus_master

Overview:
- CPU-side bus sequencer for the 8259A-compatible PIC top module.
- After a start request, performs the PIC initialisation write sequence: ICW1, ICW2, ICW3 and ICW4 where required, then OCW1.
- Runs the two-pulse interrupt-acknowledge handshake when the PIC raises INT and returns the captured vector.
- Issues EOI (OCW2) writes on request.
- Replaces hand-driven bus stimulus in system-level builds.

Parameters:
- PULSE_CYC, 2, width in clk cycles of each WR_n and INTA_n low pulse (1..15).
- GAP_CYC, 2, high time in cycles between the first and second INTA_n pulses (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  one-cycle pulse that begins the init sequence.
- cfg_icw1  in  8  ICW1 value. Bit1 = SNGL, bit0 = IC4.
- cfg_icw2  in  8  ICW2 (vector base).
- cfg_icw3  in  8  ICW3, written only when SNGL=0.
- cfg_icw4  in  8  ICW4, written only when IC4=1.
- cfg_ocw1  in  8  interrupt mask, always written last.
- eoi_req  in  1  pulse requesting an EOI write.
- eoi_cmd  in  8  OCW2 byte, sampled with eoi_req.
- int_in  in  1  PIC INT output.
- d_in  in  8  PIC data bus, read side.
- cs_n  out  1  PIC chip select.
- wr_n  out  1  PIC write strobe.
- rd_n  out  1  PIC read strobe. Held at 1; reserved.
- a0  out  1  PIC address line.
- d_out  out  8  write data.
- d_oe  out  1  write-data enable for the tristate bus.
- inta_n  out  1  interrupt acknowledge strobe.
- init_done  out  1  level signal: init sequence complete.
- busy  out  1  level signal: bus cycle in progress.
- vec_valid  out  1  one-cycle pulse: vector captured.
- vec  out  8  captured vector, held until the next capture.

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1, wr_n=1, rd_n=1, inta_n=1, a0=0, d_out=0, d_oe=0, init_done=0, busy=0, vec_valid=0, vec=0.
- Reset asserted mid-operation aborts the current cycle. Strobes are high on the first edge after rst, and init_done clears.
- Write cycle (WS_SETUP, WS_STROBE, WS_HOLD):
  - WS_SETUP, 1 cycle: cs_n=0, a0 and d_out driven, d_oe=1.
  - WS_STROBE, PULSE_CYC cycles: wr_n=0.
  - WS_HOLD, 1 cycle: wr_n=1, cs_n=0, data still driven.
  - Total 2+PULSE_CYC cycles per write. Next state is the next write or IDLE, where cs_n=1 and d_oe=0.
- Init list, latched from cfg_* on start:
  - ICW1 with a0=0.
  - ICW2 with a0=1.
  - ICW3 with a0=1 if SNGL=0.
  - ICW4 with a0=1 if IC4=1.
  - OCW1 with a0=1.
  - init_done is set in the cycle after the last WS_HOLD.
- start arriving while busy=1 is ignored. start while init_done=1 clears init_done and re-runs the sequence.
- Acknowledge sequence (only when init_done=1 and IDLE):
  - On int_in=1: IA1 (inta_n=0 for PULSE_CYC), IA_GAP (inta_n=1 for GAP_CYC), IA2 (inta_n=0 for PULSE_CYC).
  - d_in is sampled on the last IA2 cycle into vec. vec_valid pulses in the following cycle and inta_n returns to 1.
  - cs_n and d_oe stay inactive throughout.
  - Once IA1 has started, both pulses always complete, even if int_in drops.
  - int_in is not re-evaluated until IDLE.
- EOI: eoi_req latches eoi_cmd into a one-deep pending flag. The write uses a0=0. A second eoi_req while one is pending is dropped.
- Arbitration at IDLE, fixed priority: pending start, then pending EOI, then int_in. A start pulse arriving while busy is not queued. busy=1 in every non-IDLE state.
- Strobe counter: a 4-bit down-counter loaded with PULSE_CYC-1 or GAP_CYC-1.

Decomposition:
- Shared package pic_pkg:
  - state enum (IDLE, WS_SETUP, WS_STROBE, WS_HOLD, IA1, IA_GAP, IA2, IA_DONE);
  - ICW1 bit positions SNGL=1, IC4=0;
  - write-index enum (W_ICW1..W_OCW1, W_EOI).
- One natural sub-module, pic_strobe_timer: load/count/zero flag. It is reused for pulse and gap timing.

Test Plan:
- Short init: rst, then start with icw1=0x36, icw2=0xFF, ocw1=0x00, PULSE_CYC=2.
  - Exactly 3 writes: (a0=0,0x36), (a0=1,0xFF), (a0=1,0x00).
  - Each write is 4 cycles.
  - init_done rises 12 cycles after the first WS_SETUP.
- Full init: icw1=0x11 (SNGL=0, IC4=1).
  - 5 writes in order: ICW1, ICW2, ICW3, ICW4, OCW1.
  - wr_n is low exactly 2 cycles each.
- Acknowledge: after init, int_in=1 and the model drives d_in=0xFB during IA2.
  - inta_n low 2 cycles, high 2, low 2.
  - vec=0xFB with a one-cycle vec_valid.
  - cs_n stays 1 throughout.
- Same-cycle EOI and interrupt: eoi_req with eoi_cmd=0x20 in the same cycle int_in rises.
  - EOI write (a0=0, 0x20) completes first, then the INTA pair.
- Reset mid-cycle: rst asserted during WS_STROBE of ICW2.
  - wr_n=1, cs_n=1, d_oe=0, init_done=0 on the next edge.
  - No further writes until a new start.
- start while busy: a start pulse during an INTA sequence is ignored, with no extra writes after IA_DONE.
